// File: rtl/wb_intctl186.sv
// 80186-style interrupt controller on a Wishbone slave port: four sources (INT0, timers 0-2),
// priority by {PR, index}, in-service nesting, EOI handling and vectored acknowledge.
module wb_intctl186 #(
    parameter logic [7:0] VEC_INT0 = 8'h0C,
    parameter logic [7:0] VEC_T0   = 8'h08,
    parameter logic [7:0] VEC_T1   = 8'h12,
    parameter logic [7:0] VEC_T2   = 8'h13
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [4:1]  wb_adr_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic [3:0]  irq_i,
    output logic        intr_o,
    input  logic        inta_i,
    output logic [7:0]  vec_o
);

    logic        r_ack;
    logic [15:0] r_dat;
    logic [3:0]  r_mask, r_isr, r_req, r_sync1, r_sync2, r_prev;
    logic [2:0]  r_tpr, r_ipr;
    logic        r_ltm, r_inta_d, r_intr;
    logic [7:0]  r_vec;

    logic        w_acc, w_lo, w_eoi, w_cond, w_inta_rise, w_ack_hw, w_unused;
    logic [3:0]  w_edge, w_req, w_pend, w_eoi_clr, w_req_clr, w_req_n, w_isr_n, w_win_oh;
    logic [2:0]  w_pend_best, w_isr_best;
    logic [15:0] w_rdata;

    function automatic logic [4:0] src_key(input logic [1:0] idx, input logic [2:0] ipr,
                                           input logic [2:0] tpr);
        if (idx == 2'd0) src_key = {ipr, idx};
        else             src_key = {tpr, idx};
    endfunction

    // Returns {found, index} of the lowest-key source among the set bits.
    function automatic logic [2:0] best_src(input logic [3:0] bits, input logic [2:0] ipr,
                                            input logic [2:0] tpr);
        logic       found;
        logic [1:0] idx;
        logic [4:0] key;
        found = 1'b0;
        idx   = 2'd0;
        key   = 5'h1F;
        for (int i = 0; i < 4; i++) begin
            if (bits[i] && (!found || src_key(2'(i), ipr, tpr) < key)) begin
                found = 1'b1;
                idx   = 2'(i);
                key   = src_key(2'(i), ipr, tpr);
            end
        end
        best_src = {found, idx};
    endfunction

    function automatic logic [7:0] src_type(input logic [1:0] idx);
        case (idx)
            2'd0:    src_type = VEC_INT0;
            2'd1:    src_type = VEC_T0;
            2'd2:    src_type = VEC_T1;
            default: src_type = VEC_T2;
        endcase
    endfunction

    assign w_acc       = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_lo        = w_acc & wb_we_i & wb_sel_i[0];
    assign w_eoi       = w_lo & (wb_adr_i == 4'd1);
    assign w_edge      = r_sync2 & ~r_prev;
    assign w_req       = {r_req[3:1], r_ltm ? r_sync2[0] : r_req[0]};
    assign w_pend      = w_req & ~r_mask;
    assign w_pend_best = best_src(w_pend, r_ipr, r_tpr);
    assign w_isr_best  = best_src(r_isr, r_ipr, r_tpr);
    assign w_cond      = w_pend_best[2] & (~w_isr_best[2] |
                         (src_key(w_pend_best[1:0], r_ipr, r_tpr) <
                          src_key(w_isr_best[1:0], r_ipr, r_tpr)));
    assign w_inta_rise = inta_i & ~r_inta_d;
    assign w_ack_hw    = w_inta_rise & w_cond;
    assign w_win_oh    = 4'b0001 << w_pend_best[1:0];
    assign w_unused    = ^wb_dat_i[14:8];

    // Register read multiplexer.
    always_comb begin
        w_rdata = 16'h0000;
        case (wb_adr_i)
            4'd4:    w_rdata = {12'h000, r_mask};
            4'd6:    w_rdata = {12'h000, r_isr};
            4'd7:    w_rdata = {12'h000, w_req};
            4'd8:    w_rdata = {15'h0000, r_intr};
            4'd9:    w_rdata = {13'h0000, r_tpr};
            4'd12:   w_rdata = {11'h000, r_ltm, 1'b0, r_ipr};
            default: w_rdata = 16'h0000;
        endcase
    end

    // EOI clear set, judged on the in-service state before any same-cycle acknowledge.
    always_comb begin
        w_eoi_clr = 4'b0000;
        if (w_eoi) begin
            if (wb_sel_i[1] && wb_dat_i[15]) begin
                if (w_isr_best[2]) w_eoi_clr = 4'b0001 << w_isr_best[1:0];
                else               w_eoi_clr = 4'b0000;
            end else begin
                for (int i = 0; i < 4; i++)
                    w_eoi_clr[i] = r_isr[i] & (src_type(2'(i)) == wb_dat_i[7:0]);
            end
        end else begin
            w_eoi_clr = 4'b0000;
        end
    end

    // Next-state for in-service and request bits; hardware updates are applied last so they win.
    always_comb begin
        w_isr_n = r_isr;
        if (w_lo && wb_adr_i == 4'd6) w_isr_n = wb_dat_i[3:0];
        else                          w_isr_n = r_isr;
        w_isr_n = w_isr_n & ~w_eoi_clr;
        if (w_ack_hw) w_isr_n = w_isr_n | w_win_oh;
        else          w_isr_n = w_isr_n;

        w_req_clr = 4'b0000;
        if (w_ack_hw && (w_pend_best[1:0] != 2'd0 || !r_ltm)) w_req_clr = w_win_oh;
        else                                                  w_req_clr = 4'b0000;
        w_req_n = (r_req & ~w_req_clr) | w_edge;
        if (r_ltm) w_req_n[0] = r_sync2[0];
        else       w_req_n[0] = w_req_n[0];
    end

    // Bus handshake and configuration registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_ack  <= 1'b0;
            r_dat  <= 16'h0000;
            r_mask <= 4'b1110;
            r_tpr  <= 3'd7;
            r_ipr  <= 3'd7;
            r_ltm  <= 1'b0;
        end else begin
            r_ack <= w_acc;
            r_dat <= w_acc ? w_rdata : 16'h0000;
            if (w_lo) begin
                case (wb_adr_i)
                    4'd4:    r_mask <= wb_dat_i[3:0];
                    4'd9:    r_tpr  <= wb_dat_i[2:0];
                    4'd12: begin
                        r_ipr <= wb_dat_i[2:0];
                        r_ltm <= wb_dat_i[4];
                    end
                    default: r_mask <= r_mask;
                endcase
            end
        end
    end

    // Request synchronisers, pending/in-service state and CPU-facing outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_sync1  <= 4'b0000;
            r_sync2  <= 4'b0000;
            r_prev   <= 4'b0000;
            r_req    <= 4'b0000;
            r_isr    <= 4'b0000;
            r_inta_d <= 1'b1;
            r_intr   <= 1'b0;
            r_vec    <= 8'h00;
        end else begin
            r_sync1  <= irq_i;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_req    <= w_req_n;
            r_isr    <= w_isr_n;
            r_inta_d <= inta_i;
            r_intr   <= w_cond & ~inta_i;
            if (!inta_i && w_cond) r_vec <= src_type(w_pend_best[1:0]);
            else                   r_vec <= r_vec;
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign intr_o   = r_intr;
    assign vec_o    = r_vec;

endmodule

// File: tb/tb_wb_intctl186.sv
// Directed bench for wb_intctl186: bus map, edge/level requests, nesting, EOI and reset.
module tb_wb_intctl186;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [4:1]  wb_adr_i;
    logic [1:0]  wb_sel_i;
    logic [15:0] wb_dat_i, wb_dat_o;
    logic        wb_ack_o;
    logic [3:0]  irq_i;
    logic        intr_o, inta_i;
    logic [7:0]  vec_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];
    logic [15:0] rd;

    always #5 clk = ~clk;

    wb_intctl186 dut (
        .clk(clk), .rst_b(rst_b),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .irq_i(irq_i), .intr_o(intr_o), .inta_i(inta_i), .vec_o(vec_o)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboarded check: expectation queued, then popped against the DUT output.
    task automatic sb_chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        chk(tag_q.pop_front(), obs, exp_q.pop_front());
    endtask

    task automatic xfer(input logic we, input logic [3:0] adr, input logic [1:0] sel,
                        input logic [15:0] dat, output logic [15:0] data);
        logic got;
        got      = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            got = wb_ack_o;
        end
        data     = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        n_cmp++;
        assert (got) else begin
            n_bad++;
            $error("FAIL ack_timeout: observed ack=%b expected ack=1", got);
        end
        tick(1);
        chk("ack_single", {15'h0000, wb_ack_o}, 16'h0000);
    endtask

    task automatic wr(input logic [3:0] adr, input logic [1:0] sel, input logic [15:0] dat);
        logic [15:0] dummy;
        xfer(1'b1, adr, sel, dat, dummy);
    endtask

    task automatic rd_exp(input string tag, input logic [3:0] adr, input logic [15:0] exp);
        logic [15:0] data;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        xfer(1'b0, adr, 2'b11, 16'h0000, data);
        chk(tag_q.pop_front(), data, exp_q.pop_front());
    endtask

    task automatic wait_intr(input string tag, input logic exp, input int budget);
        for (int i = 0; i < budget && intr_o !== exp; i++) tick(1);
        sb_chk(tag, {15'h0000, intr_o}, {15'h0000, exp});
    endtask

    task automatic inta_pulse();
        inta_i = 1'b1;
        tick(1);
        inta_i = 1'b0;
        tick(1);
    endtask

    initial begin
        rst_b = 1'b0; inta_i = 1'b0; irq_i = 4'b0000;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = 4'd0; wb_sel_i = 2'b00; wb_dat_i = 16'h0000;
        tick(3);
        chk("rst_intr", {15'h0000, intr_o}, 16'h0000);
        chk("rst_vec",  {8'h00, vec_o},     16'h0000);
        chk("rst_ack",  {15'h0000, wb_ack_o}, 16'h0000);
        chk("rst_dat",  wb_dat_o,           16'h0000);
        rst_b = 1'b1;
        tick(1);
        rd_exp("rst_mask",  4'd4, 16'h000E);
        rd_exp("rst_i0con", 4'd12, 16'h0007);

        // Edge INT0 after reset
        irq_i[0] = 1'b1;
        wait_intr("int0_intr", 1'b1, 6);
        sb_chk("int0_vec", {8'h00, vec_o}, 16'h000C);
        rd_exp("insts_hi", 4'd8, 16'h0001);
        inta_pulse();
        rd_exp("int0_isr", 4'd6, 16'h0001);
        rd_exp("int0_req", 4'd7, 16'h0000);
        chk("int0_intr_lo", {15'h0000, intr_o}, 16'h0000);
        wr(4'd1, 2'b11, 16'h8000);
        rd_exp("eoi_clear", 4'd6, 16'h0000);

        // Nesting: timer 0 at PR0 pre-empts INT0 at PR5
        wr(4'd9, 2'b11, 16'h0000);
        wr(4'd12, 2'b11, 16'h0005);
        wr(4'd4, 2'b11, 16'h0000);
        irq_i[0] = 1'b0;
        tick(4);
        irq_i[0] = 1'b1;
        wait_intr("nest_int0", 1'b1, 6);
        inta_pulse();
        irq_i[1] = 1'b1;
        wait_intr("nest_t0_intr", 1'b1, 6);
        sb_chk("nest_t0_vec", {8'h00, vec_o}, 16'h0008);
        inta_pulse();
        rd_exp("nest_isr", 4'd6, 16'h0003);
        wr(4'd1, 2'b11, 16'h8000);
        rd_exp("nest_eoi", 4'd6, 16'h0001);

        // Blocking: T2 at PR7 cannot pre-empt INT0 at PR7
        wr(4'd9, 2'b11, 16'h0007);
        wr(4'd12, 2'b11, 16'h0007);
        irq_i[3] = 1'b1;
        tick(6);
        chk("blk_intr_lo", {15'h0000, intr_o}, 16'h0000);
        rd_exp("blk_req", 4'd7, 16'h0008);
        wr(4'd1, 2'b11, 16'h000C);
        wait_intr("blk_intr_hi", 1'b1, 6);
        sb_chk("blk_vec", {8'h00, vec_o}, 16'h0013);
        inta_pulse();
        rd_exp("blk_isr", 4'd6, 16'h0008);
        wr(4'd1, 2'b11, 16'h0013);
        rd_exp("blk_eoi", 4'd6, 16'h0000);

        // Level mode on INT0 (irq_i[0] still high)
        wr(4'd12, 2'b11, 16'h0017);
        wait_intr("lvl_intr", 1'b1, 6);
        sb_chk("lvl_vec", {8'h00, vec_o}, 16'h000C);
        inta_pulse();
        rd_exp("lvl_isr", 4'd6, 16'h0001);
        rd_exp("lvl_req", 4'd7, 16'h0001);
        chk("lvl_blocked", {15'h0000, intr_o}, 16'h0000);
        wr(4'd1, 2'b11, 16'h8000);
        wait_intr("lvl_reassert", 1'b1, 6);
        irq_i[0] = 1'b0;
        tick(4);
        rd_exp("lvl_req_lo", 4'd7, 16'h0000);
        chk("lvl_intr_lo", {15'h0000, intr_o}, 16'h0000);

        // Bus edge cases and spurious acknowledge
        wr(4'd2, 2'b11, 16'hFFFF);
        rd_exp("unmapped", 4'd2, 16'h0000);
        wr(4'd4, 2'b10, 16'h000F);
        rd_exp("mask_sel_hi", 4'd4, 16'h0000);
        inta_pulse();
        chk("spur_vec", {8'h00, vec_o}, 16'h000C);
        chk("spur_intr", {15'h0000, intr_o}, 16'h0000);
        rd_exp("spur_isr", 4'd6, 16'h0000);
        rd_exp("spur_req", 4'd7, 16'h0000);

        // Reset mid-inta with INSERV=0011
        wr(4'd6, 2'b11, 16'h0003);
        rd_exp("pre_rst_isr", 4'd6, 16'h0003);
        inta_i = 1'b1;
        tick(1);
        #2 rst_b = 1'b0;
        #1;
        chk("arst_vec",  {8'h00, vec_o},       16'h0000);
        chk("arst_intr", {15'h0000, intr_o},   16'h0000);
        chk("arst_ack",  {15'h0000, wb_ack_o}, 16'h0000);
        chk("arst_dat",  wb_dat_o,             16'h0000);
        tick(2);
        inta_i = 1'b0;
        rst_b  = 1'b1;
        tick(1);
        rd_exp("arst_mask",  4'd4, 16'h000E);
        rd_exp("arst_isr",   4'd6, 16'h0000);
        rd_exp("arst_tcu",   4'd9, 16'h0007);
        rd_exp("arst_i0con", 4'd12, 16'h0007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_intctl186.md
WB_INTCTL186 -- requirements
Module: wb_intctl186

Interface
REQ-001 SHALL provide these parameters, one per line as name, default, meaning:
- VEC_INT0, 8'h0C, type for source 0 (Tube INT0).
- VEC_T0, 8'h08, type for source 1 (timer 0).
- VEC_T1, 8'h12, type for source 2 (timer 1).
- VEC_T2, 8'h13, type for source 3 (timer 2).
REQ-002 SHALL provide these ports, one per line as name, direction, width, meaning:
- clk  in  1  sole clock.
- rst_b  in  1  reset.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  4 [4:1]  word offset from I/O 0xFF20.
- wb_sel_i  in  2  byte lanes.
- wb_dat_i  in  16  write data.
- wb_dat_o  out  16  read data.
- wb_ack_o  out  1  acknowledge.
- irq_i  in  4  async requests; bit0 INT0, bit1..3 T0..T2.
- intr_o  out  1  interrupt request to CPU (wb_tgc_i).
- inta_i  in  1  CPU acknowledge (wb_tgc_o).
- vec_o  out  8  vector type, muxed onto CPU data during inta.
REQ-003 SHALL use one clock; reset is asynchronous and active-low (clk, rst_b).

Function
REQ-004 SHALL ack a bus access one cycle after cyc&stb, as a registered single-cycle pulse; no ack in the cycle after an ack; read data valid with ack.
REQ-005 SHALL decode this word map; all other offsets read 0 and ignore writes:
- 1 EOI: write-only, reads 0.
- 4 MASK[3:0]: R/W.
- 6 INSERV[3:0]: R/W.
- 7 REQST[3:0]: read-only.
- 8 INSTS: bit0 = intr_o.
- 9 TCUCON: [2:0] PR.
- 12 I0CON: [2:0] PR, [4] LTM.
REQ-006 SHALL write a field only when the wb_sel_i lane holding it is set.
REQ-007 SHALL pass irq_i through a 2-flop synchroniser per bit.
REQ-008 SHALL set REQST[0] on a synchronised rising edge when I0CON.LTM=0; when LTM=1, REQST[0] SHALL equal the synchronised level.
REQ-009 SHALL make timer sources always edge-mode and share the TCUCON PR field.
REQ-010 SHALL rank sources by key {PR, index}, lowest key winning.
REQ-011 SHALL register intr_o high when the best pending unmasked request key is below the best INSERV key, or when INSERV=0 and such a request exists.
REQ-012 SHALL register vec_o each cycle with the winner's type while inta_i is low, and hold it while inta_i is high.
REQ-013 SHALL, on the first cycle inta_i is sampled high (rising edge):
- set the winner's INSERV bit;
- clear its REQST bit if edge-mode;
- drive intr_o low from the next cycle until inta_i falls, then re-evaluate.
REQ-014 SHALL take no state action on an inta_i rising edge with no winner (spurious); vec_o keeps its last value.
REQ-015 SHALL handle EOI writes as follows:
- bit15=1 (non-specific): clear the lowest-key INSERV bit.
- bit15=0 (specific): clear the INSERV bit whose type equals bits[7:0].
- INSERV=0 or no type match: no effect.
REQ-016 SHALL resolve simultaneous events as follows:
- a new edge in the same cycle as the ack-clear of that source leaves REQST set;
- an EOI and an ack in the same cycle both apply, with the EOI judged on pre-ack INSERV and the set winning on the same bit;
- a bus write to INSERV/MASK and a hardware update in the same cycle: the hardware update wins.

Reset
REQ-017 SHALL, while rst_b is low, asynchronously force:
- MASK=4'b1110, INSERV=0, REQST=0;
- TCUCON.PR=7, I0CON.PR=7, LTM=0;
- synchronisers 0;
- wb_ack_o=0, wb_dat_o=0, intr_o=0, vec_o=0.
REQ-018 SHALL abandon any bus access or inta sequence in progress when reset asserts, with no ack after release until a new cyc&stb.

Verification
REQ-019 Bench SHALL cover:
- Edge INT0 after reset: irq_i[0] 0->1 -> intr_o=1 within 4 clks, vec_o=8'h0C; inta_i pulse -> INSERV=0001, REQST=0000, intr_o=0.
- Nesting: write TCUCON=0, I0CON=5, MASK=0; INT0 acked; T0 edge -> intr_o=1, vec_o=8'h08; after ack INSERV=0011; non-specific EOI -> INSERV=0001.
- Blocking: INT0 in service at PR7, T2 edge at PR7 -> intr_o stays 0; specific EOI 16'h000C -> intr_o=1, vec_o=8'h13.
- Level mode: LTM=1, irq_i[0] held high; ack then EOI -> intr_o re-asserts; irq_i low -> REQST[0]=0, intr_o=0.
- Bus/edge cases: write to offset 2 reads 0; sel=2'b10 write to MASK leaves MASK; spurious inta_i with nothing pending changes nothing.
- Reset: rst_b low mid-inta with INSERV=0011 -> all outputs 0 and MASK=1110 immediately.
